// File: rtl/core_controller_pkg.sv
// Shared types and constants for the core controller and its datapath neighbours.
package core_controller_pkg;

    typedef logic [31:0] data_t;
    typedef logic [31:0] addr_t;

    typedef logic [1:0] sel_pc_t;
    localparam sel_pc_t PC_SEL_PLUS4   = 2'd0;
    localparam sel_pc_t PC_SEL_BRANCH  = 2'd1;
    localparam sel_pc_t PC_SEL_JAL     = 2'd2;
    localparam sel_pc_t PC_SEL_JALR    = 2'd3;
    localparam sel_pc_t PC_SEL_DEFAULT = PC_SEL_PLUS4;

    typedef logic [1:0] ctrl_state_t;
    localparam ctrl_state_t S_FETCH = 2'd0;
    localparam ctrl_state_t S_EXEC  = 2'd1;
    localparam ctrl_state_t S_MEM   = 2'd2;
    localparam ctrl_state_t S_HALT  = 2'd3;

    typedef enum logic [1:0] {
        ERR_NONE          = 2'd0,
        ERR_MEM_TIMEOUT   = 2'd1,
        ERR_MISALIGNED_PC = 2'd2
    } err_t;

    localparam data_t      EBREAK    = 32'h0010_0073;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    function automatic logic is_mem_op(input data_t instr);
        return (instr[6:0] == OPC_LOAD) || (instr[6:0] == OPC_STORE);
    endfunction

endpackage

// File: rtl/core_controller_perf_counters.sv
// Free-running cycle and retired-instruction counters; both wrap silently.
module perf_counters #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cycle_en,
    input  logic             instret_en,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (cycle_en)
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (instret_en)
                instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/core_controller.sv
// Multi-cycle sequencer: gates fetch, decides commit, and supplies the PC the
// datapath loads every clock (holding pc_q whenever nothing commits).
module core_controller
    import core_controller_pkg::*;
#(
    parameter addr_t RESET_PC    = 32'h0,
    parameter int    MEM_TIMEOUT = 255,
    parameter int    CNT_W       = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_done,
    input  data_t            ir,
    input  sel_pc_t          pc_sel,
    input  logic             br_taken,
    input  addr_t            next_pc,
    input  logic             memory_done,
    input  logic             halt_req,
    input  logic             resume,
    output logic             c_fetch_stall,
    output sel_pc_t          c_pc_sel,
    output logic             c_br_taken,
    output addr_t            c_next_pc,
    output logic             halted,
    output err_t             err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_t      state, state_nx;
    addr_t            pc_q, pc_nx;
    err_t             err_q, err_nx;
    logic [TMO_W-1:0] tmo_q, tmo_nx;
    logic             commit, commit_ok;

    always_comb begin
        state_nx  = state;
        pc_nx     = pc_q;
        err_nx    = err_q;
        tmo_nx    = tmo_q;
        commit    = 1'b0;
        commit_ok = 1'b0;
        case (state)
            S_FETCH: begin
                if (fetch_done)
                    state_nx = S_EXEC;
            end
            S_EXEC: begin
                if (ir == EBREAK) begin
                    state_nx = S_HALT;
                end else if (is_mem_op(ir)) begin
                    state_nx = S_MEM;
                    tmo_nx   = '0;
                end else begin
                    commit = 1'b1;
                end
            end
            S_MEM: begin
                if (memory_done) begin
                    commit = 1'b1;
                end else begin
                    tmo_nx = tmo_q + 1'b1;
                    if (tmo_nx == TMO_W'(MEM_TIMEOUT)) begin
                        err_nx   = ERR_MEM_TIMEOUT;
                        state_nx = S_HALT;
                    end
                end
            end
            S_HALT: begin
                // A latched error can only be cleared by reset.
                if (resume && err_q == ERR_NONE)
                    state_nx = S_FETCH;
            end
            default: state_nx = S_FETCH;
        endcase

        commit_ok = commit && (next_pc[1:0] == 2'b00);
        if (commit) begin
            if (!commit_ok) begin
                err_nx   = ERR_MISALIGNED_PC;
                state_nx = S_HALT;
            end else begin
                // halt_req only takes effect on an instruction boundary.
                pc_nx    = next_pc;
                state_nx = halt_req ? S_HALT : S_FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            pc_q  <= RESET_PC;
            err_q <= ERR_NONE;
            tmo_q <= '0;
        end else begin
            state <= state_nx;
            pc_q  <= pc_nx;
            err_q <= err_nx;
            tmo_q <= tmo_nx;
        end
    end

    // Stall is forced while reset is asserted because the reset state is S_FETCH.
    assign c_fetch_stall = !rst_n || (state != S_FETCH);
    assign c_next_pc     = commit_ok ? next_pc : pc_q;
    assign c_pc_sel      = (state == S_EXEC || state == S_MEM) ? pc_sel : PC_SEL_DEFAULT;
    assign c_br_taken    = (state == S_EXEC || state == S_MEM) ? br_taken : 1'b0;
    assign halted        = (state == S_HALT);
    assign err           = err_q;

    perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf_counters (
        .clk         (clk),
        .rst_n       (rst_n),
        .cycle_en    (state != S_HALT),
        .instret_en  (commit_ok),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

endmodule

// File: tb/tb_core_controller.sv
// Directed bench for core_controller: ALU, load/store, halt, EBREAK, errors, reset.
module tb_core_controller;
    import core_controller_pkg::*;

    localparam data_t INS_ADDI = 32'h0010_0093;
    localparam data_t INS_LW   = 32'h0000_a103;
    localparam data_t INS_SW   = 32'h0020_a023;
    localparam data_t INS_BEQ  = 32'h0000_0063;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_done;
    data_t       ir;
    sel_pc_t     pc_sel;
    logic        br_taken;
    addr_t       next_pc;
    logic        memory_done;
    logic        halt_req;
    logic        resume;
    logic        c_fetch_stall;
    sel_pc_t     c_pc_sel;
    logic        c_br_taken;
    addr_t       c_next_pc;
    logic        halted;
    err_t        err;
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    core_controller #(
        .RESET_PC    (32'h0),
        .MEM_TIMEOUT (8),
        .CNT_W       (64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_done    (fetch_done),
        .ir            (ir),
        .pc_sel        (pc_sel),
        .br_taken      (br_taken),
        .next_pc       (next_pc),
        .memory_done   (memory_done),
        .halt_req      (halt_req),
        .resume        (resume),
        .c_fetch_stall (c_fetch_stall),
        .c_pc_sel      (c_pc_sel),
        .c_br_taken    (c_br_taken),
        .c_next_pc     (c_next_pc),
        .halted        (halted),
        .err           (err),
        .cycle_cnt     (cycle_cnt),
        .instret_cnt   (instret_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_done  = 1'b0;
        ir          = 32'h0000_0013;
        pc_sel      = PC_SEL_DEFAULT;
        br_taken    = 1'b0;
        next_pc     = 32'h0;
        memory_done = 1'b0;
        halt_req    = 1'b0;
        resume      = 1'b0;
    endtask

    task automatic do_fetch();
        fetch_done = 1'b1;
        tick();
        fetch_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        n_chk++; if (c_fetch_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %0h want 1", c_fetch_stall); end
        n_chk++; if (c_next_pc !== 32'h0) begin n_fail++; $display("FAIL reset_next_pc: got %0h want 0", c_next_pc); end
        n_chk++; if (c_pc_sel !== PC_SEL_DEFAULT) begin n_fail++; $display("FAIL reset_pc_sel: got %0h want %0h", c_pc_sel, PC_SEL_DEFAULT); end
        n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %0h want 0", halted); end
        n_chk++; if (err !== ERR_NONE) begin n_fail++; $display("FAIL reset_err: got %0h want 0", err); end
        n_chk++; if (cycle_cnt !== 64'd0) begin n_fail++; $display("FAIL reset_cycle: got %0d want 0", cycle_cnt); end
        n_chk++; if (instret_cnt !== 64'd0) begin n_fail++; $display("FAIL reset_instret: got %0d want 0", instret_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        for (int i = 0; i < 3; i++) begin
            fetch_done = (i == 2);
            #1;
            n_chk++; if (c_fetch_stall !== 1'b0) begin n_fail++; $display("FAIL alu_fetch_stall[%0d]: got %0h want 0", i, c_fetch_stall); end
            n_chk++; if (c_next_pc !== 32'h0) begin n_fail++; $display("FAIL alu_fetch_pc[%0d]: got %0h want 0", i, c_next_pc); end
            tick();
        end
        fetch_done = 1'b0;
        ir         = INS_ADDI;
        next_pc    = 32'h4;
        #1;
        n_chk++; if (c_fetch_stall !== 1'b1) begin n_fail++; $display("FAIL alu_exec_stall: got %0h want 1", c_fetch_stall); end
        n_chk++; if (c_next_pc !== 32'h4) begin n_fail++; $display("FAIL alu_commit_pc: got %0h want 4", c_next_pc); end
        tick();
        idle_inputs();
        #1;
        n_chk++; if (c_fetch_stall !== 1'b0) begin n_fail++; $display("FAIL alu_after_stall: got %0h want 0", c_fetch_stall); end
        n_chk++; if (c_next_pc !== 32'h4) begin n_fail++; $display("FAIL alu_after_pc: got %0h want 4", c_next_pc); end
        n_chk++; if (instret_cnt !== 64'd1) begin n_fail++; $display("FAIL alu_instret: got %0d want 1", instret_cnt); end
        n_chk++; if (cycle_cnt !== 64'd4) begin n_fail++; $display("FAIL alu_cycle: got %0d want 4", cycle_cnt); end
    endtask

    task automatic test_load();
        do_fetch();
        ir      = INS_LW;
        next_pc = 32'h8;
        #1;
        n_chk++; if (c_next_pc !== 32'h4) begin n_fail++; $display("FAIL ld_exec_pc: got %0h want 4", c_next_pc); end
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            n_chk++; if (c_next_pc !== 32'h4) begin n_fail++; $display("FAIL ld_wait_pc[%0d]: got %0h want 4", i, c_next_pc); end
            n_chk++; if (c_fetch_stall !== 1'b1) begin n_fail++; $display("FAIL ld_wait_stall[%0d]: got %0h want 1", i, c_fetch_stall); end
            tick();
        end
        memory_done = 1'b1;
        #1;
        n_chk++; if (c_next_pc !== 32'h8) begin n_fail++; $display("FAIL ld_commit_pc: got %0h want 8", c_next_pc); end
        tick();
        idle_inputs();
        #1;
        n_chk++; if (instret_cnt !== 64'd2) begin n_fail++; $display("FAIL ld_instret: got %0d want 2", instret_cnt); end
        n_chk++; if (c_fetch_stall !== 1'b0) begin n_fail++; $display("FAIL ld_after_stall: got %0h want 0", c_fetch_stall); end
        n_chk++; if (c_next_pc !== 32'h8) begin n_fail++; $display("FAIL ld_after_pc: got %0h want 8", c_next_pc); end
    endtask

    task automatic test_halt_req_mid_mem();
        do_fetch();
        ir      = INS_LW;
        next_pc = 32'hC;
        tick();
        halt_req = 1'b1;
        tick();
        memory_done = 1'b1;
        #1;
        n_chk++; if (c_next_pc !== 32'hC) begin n_fail++; $display("FAIL hreq_commit_pc: got %0h want c", c_next_pc); end
        tick();
        idle_inputs();
        #1;
        n_chk++; if (halted !== 1'b1) begin n_fail++; $display("FAIL hreq_halted: got %0h want 1", halted); end
        n_chk++; if (c_next_pc !== 32'hC) begin n_fail++; $display("FAIL hreq_pc: got %0h want c", c_next_pc); end
        n_chk++; if (instret_cnt !== 64'd3) begin n_fail++; $display("FAIL hreq_instret: got %0d want 3", instret_cnt); end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        #1;
        n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL hreq_resume_halted: got %0h want 0", halted); end
        n_chk++; if (c_fetch_stall !== 1'b0) begin n_fail++; $display("FAIL hreq_resume_stall: got %0h want 0", c_fetch_stall); end
    endtask

    task automatic test_async_reset();
        do_fetch();
        ir      = INS_LW;
        next_pc = 32'h10;
        tick();
        rst_n = 1'b0;
        #1;
        n_chk++; if (c_fetch_stall !== 1'b1) begin n_fail++; $display("FAIL arst_stall: got %0h want 1", c_fetch_stall); end
        n_chk++; if (c_next_pc !== 32'h0) begin n_fail++; $display("FAIL arst_pc: got %0h want 0", c_next_pc); end
        n_chk++; if (c_pc_sel !== PC_SEL_DEFAULT) begin n_fail++; $display("FAIL arst_pc_sel: got %0h want %0h", c_pc_sel, PC_SEL_DEFAULT); end
        n_chk++; if (instret_cnt !== 64'd0) begin n_fail++; $display("FAIL arst_instret: got %0d want 0", instret_cnt); end
        n_chk++; if (cycle_cnt !== 64'd0) begin n_fail++; $display("FAIL arst_cycle: got %0d want 0", cycle_cnt); end
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_ebreak();
        do_fetch();
        ir      = INS_ADDI;
        next_pc = 32'h40;
        tick();
        idle_inputs();
        do_fetch();
        ir      = EBREAK;
        next_pc = 32'h44;
        #1;
        n_chk++; if (c_next_pc !== 32'h40) begin n_fail++; $display("FAIL ebrk_exec_pc: got %0h want 40", c_next_pc); end
        tick();
        idle_inputs();
        #1;
        n_chk++; if (halted !== 1'b1) begin n_fail++; $display("FAIL ebrk_halted: got %0h want 1", halted); end
        n_chk++; if (c_next_pc !== 32'h40) begin n_fail++; $display("FAIL ebrk_pc: got %0h want 40", c_next_pc); end
        n_chk++; if (cycle_cnt !== 64'd4) begin n_fail++; $display("FAIL ebrk_cycle_enter: got %0d want 4", cycle_cnt); end
        repeat (3) tick();
        n_chk++; if (cycle_cnt !== 64'd4) begin n_fail++; $display("FAIL ebrk_cycle_frozen: got %0d want 4", cycle_cnt); end
        n_chk++; if (instret_cnt !== 64'd1) begin n_fail++; $display("FAIL ebrk_instret: got %0d want 1", instret_cnt); end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        #1;
        n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL ebrk_resume: got %0h want 0", halted); end
        n_chk++; if (cycle_cnt !== 64'd4) begin n_fail++; $display("FAIL ebrk_cycle_resume: got %0d want 4", cycle_cnt); end
        tick();
        n_chk++; if (cycle_cnt !== 64'd5) begin n_fail++; $display("FAIL ebrk_cycle_counts: got %0d want 5", cycle_cnt); end
    endtask

    task automatic test_branch();
        do_fetch();
        ir       = INS_BEQ;
        pc_sel   = PC_SEL_BRANCH;
        br_taken = 1'b1;
        next_pc  = 32'h102;
        #1;
        n_chk++; if (c_pc_sel !== PC_SEL_BRANCH) begin n_fail++; $display("FAIL br_pc_sel: got %0h want %0h", c_pc_sel, PC_SEL_BRANCH); end
        n_chk++; if (c_br_taken !== 1'b1) begin n_fail++; $display("FAIL br_taken: got %0h want 1", c_br_taken); end
        n_chk++; if (c_next_pc !== 32'h40) begin n_fail++; $display("FAIL br_misal_exec_pc: got %0h want 40", c_next_pc); end
        tick();
        idle_inputs();
        #1;
        n_chk++; if (halted !== 1'b1) begin n_fail++; $display("FAIL br_misal_halted: got %0h want 1", halted); end
        n_chk++; if (err !== ERR_MISALIGNED_PC) begin n_fail++; $display("FAIL br_misal_err: got %0h want %0h", err, ERR_MISALIGNED_PC); end
        n_chk++; if (c_next_pc !== 32'h40) begin n_fail++; $display("FAIL br_misal_pc: got %0h want 40", c_next_pc); end
        n_chk++; if (c_pc_sel !== PC_SEL_DEFAULT) begin n_fail++; $display("FAIL br_halt_pc_sel: got %0h want %0h", c_pc_sel, PC_SEL_DEFAULT); end
        n_chk++; if (instret_cnt !== 64'd1) begin n_fail++; $display("FAIL br_misal_instret: got %0d want 1", instret_cnt); end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        #1;
        n_chk++; if (halted !== 1'b1) begin n_fail++; $display("FAIL br_resume_ignored: got %0h want 1", halted); end
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        do_fetch();
        ir       = INS_BEQ;
        pc_sel   = PC_SEL_BRANCH;
        br_taken = 1'b1;
        next_pc  = 32'h100;
        #1;
        n_chk++; if (c_next_pc !== 32'h100) begin n_fail++; $display("FAIL br_commit_pc: got %0h want 100", c_next_pc); end
        tick();
        idle_inputs();
        #1;
        n_chk++; if (c_next_pc !== 32'h100) begin n_fail++; $display("FAIL br_after_pc: got %0h want 100", c_next_pc); end
        n_chk++; if (err !== ERR_NONE) begin n_fail++; $display("FAIL br_after_err: got %0h want 0", err); end
        n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL br_after_halted: got %0h want 0", halted); end
    endtask

    task automatic test_timeout();
        do_fetch();
        ir = INS_SW;
        tick();
        for (int i = 1; i <= 8; i++) begin
            #1;
            n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL tmo_wait_halted[%0d]: got %0h want 0", i, halted); end
            tick();
        end
        idle_inputs();
        #1;
        n_chk++; if (halted !== 1'b1) begin n_fail++; $display("FAIL tmo_halted: got %0h want 1", halted); end
        n_chk++; if (err !== ERR_MEM_TIMEOUT) begin n_fail++; $display("FAIL tmo_err: got %0h want %0h", err, ERR_MEM_TIMEOUT); end
        n_chk++; if (instret_cnt !== 64'd1) begin n_fail++; $display("FAIL tmo_instret: got %0d want 1", instret_cnt); end
        n_chk++; if (c_next_pc !== 32'h100) begin n_fail++; $display("FAIL tmo_pc: got %0h want 100", c_next_pc); end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        #1;
        n_chk++; if (halted !== 1'b1) begin n_fail++; $display("FAIL tmo_resume_ignored: got %0h want 1", halted); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_halt_req_mid_mem();
        test_async_reset();
        test_ebreak();
        test_branch();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
